// File: rtl/spimem_scheduler.sv
// spimem_scheduler: round-robin arbiter and Wishbone master that shares the
// SPI flash reader between N_REQ requesters. A granted job programs
// READ_ADDR, READ_LENGTH and CONTROL.start, then polls CONTROL.busy until the
// reader finishes. The job reports done (and err when flagged) to its owner.
module spimem_scheduler #(
  parameter int                         N_REQ           = 2,
  parameter int                         ADDRESS_WIDTH   = 16,
  parameter int                         DATA_WIDTH      = 32,
  parameter int                         LEN_WIDTH       = 9,
  parameter int                         MAX_LEN         = 256,
  parameter logic [ADDRESS_WIDTH-1:0]   SPIMEM_BASE     = '0,
  parameter int                         REG_CONTROL     = 0,
  parameter int                         REG_READ_ADDR   = 1,
  parameter int                         REG_READ_LENGTH = 2,
  parameter int                         POLL_GAP        = 8,
  parameter int                         ACK_TIMEOUT     = 64,
  parameter int                         BUSY_TIMEOUT    = 65535
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*32-1:0]           addr_i,
  input  logic [N_REQ*LEN_WIDTH-1:0]    len_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_REQ-1:0]              done_o,
  output logic [N_REQ-1:0]              err_o,
  output logic [ADDRESS_WIDTH-1:0]      adr_o,
  output logic [DATA_WIDTH-1:0]         dat_o,
  input  logic [DATA_WIDTH-1:0]         dat_i,
  output logic                          we_o,
  output logic [DATA_WIDTH/8-1:0]       sel_o,
  output logic                          stb_o,
  output logic                          cyc_o,
  input  logic                          ack_i,
  output logic [2:0]                    cti_o,
  output logic                          busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam int BSY_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [ADDRESS_WIDTH-1:0] ADR_CTRL = ADDRESS_WIDTH'(SPIMEM_BASE + REG_CONTROL);
  localparam logic [ADDRESS_WIDTH-1:0] ADR_ADDR = ADDRESS_WIDTH'(SPIMEM_BASE + REG_READ_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] ADR_LEN  = ADDRESS_WIDTH'(SPIMEM_BASE + REG_READ_LENGTH);

  localparam logic [LEN_WIDTH:0] MAX_LEN_C = (LEN_WIDTH + 1)'(MAX_LEN);
  localparam logic [ACK_W-1:0]   ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [BSY_W-1:0]   BSY_LAST  = BSY_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WR_ADDR,
    S_WR_LEN,
    S_WR_CTRL,
    S_POLL_RD,
    S_POLL_WAIT,
    S_DONE
  } state_t;

  // State and job registers
  state_t                     r_state;
  logic [PTR_W-1:0]           r_ptr;
  logic [N_REQ-1:0]           r_gnt;
  logic [31:0]                r_addr;
  logic [LEN_WIDTH-1:0]       r_len;
  logic                       r_err;
  // Bus registers (stb always mirrors cyc)
  logic                       r_cyc;
  logic                       r_we;
  logic [ADDRESS_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]      r_dat;
  // Counters
  logic [ACK_W-1:0]           r_ack_cnt;
  logic [GAP_W-1:0]           r_gap_cnt;
  logic [BSY_W-1:0]           r_busy_cnt;

  // Next-state values
  state_t                     w_state_next;
  logic [PTR_W-1:0]           w_ptr_next;
  logic [N_REQ-1:0]           w_gnt_next;
  logic [31:0]                w_addr_next;
  logic [LEN_WIDTH-1:0]       w_len_next;
  logic                       w_err_next;
  logic                       w_cyc_next;
  logic                       w_we_next;
  logic [ADDRESS_WIDTH-1:0]   w_adr_next;
  logic [DATA_WIDTH-1:0]      w_dat_next;
  logic [ACK_W-1:0]           w_ack_cnt_next;
  logic [GAP_W-1:0]           w_gap_cnt_next;
  logic [BSY_W-1:0]           w_busy_cnt_next;

  // Arbiter and write-phase helpers
  logic                       w_pick_valid;
  logic [PTR_W-1:0]           w_pick_idx;
  int                         w_scan;
  logic [ADDRESS_WIDTH-1:0]   w_wr_adr;
  logic [DATA_WIDTH-1:0]      w_wr_dat;
  state_t                     w_wr_next;
  logic                       w_ack_expired;
  logic                       w_busy_expired;

  // Round-robin search: scan from farthest to nearest so the requester
  // closest after the pointer is the last (winning) assignment.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    w_scan       = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_scan = int'(r_ptr) + i;
      if (w_scan >= N_REQ) begin
        w_scan = w_scan - N_REQ;
      end
      if (req_i[w_scan[PTR_W-1:0]]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = w_scan[PTR_W-1:0];
      end
    end
  end

  // Register address, write data and successor for the current write state
  always_comb begin
    w_wr_adr  = ADR_ADDR;
    w_wr_dat  = DATA_WIDTH'(r_addr);
    w_wr_next = S_WR_LEN;
    case (r_state)
      S_WR_LEN: begin
        w_wr_adr  = ADR_LEN;
        w_wr_dat  = DATA_WIDTH'(r_len);
        w_wr_next = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        w_wr_adr  = ADR_CTRL;
        w_wr_dat  = DATA_WIDTH'(1);
        w_wr_next = S_POLL_RD;
      end
      default: ;
    endcase
  end

  assign w_ack_expired  = r_cyc && !ack_i && (r_ack_cnt == ACK_LAST);
  assign w_busy_expired = (r_busy_cnt == BSY_LAST);

  // Next-state and next-bus logic
  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_gnt_next      = r_gnt;
    w_addr_next     = r_addr;
    w_len_next      = r_len;
    w_err_next      = r_err;
    w_cyc_next      = r_cyc;
    w_we_next       = r_we;
    w_adr_next      = r_adr;
    w_dat_next      = r_dat;
    w_ack_cnt_next  = r_ack_cnt;
    w_gap_cnt_next  = r_gap_cnt;
    w_busy_cnt_next = r_busy_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_state_next = S_GRANT;
          w_gnt_next   = N_REQ'(1) << w_pick_idx;
          w_ptr_next   = w_pick_idx;
          w_addr_next  = addr_i[int'(w_pick_idx)*32 +: 32];
          w_len_next   = len_i[int'(w_pick_idx)*LEN_WIDTH +: LEN_WIDTH];
          w_err_next   = 1'b0;
        end
      end

      S_GRANT: begin
        if (r_len == '0) begin
          w_state_next = S_DONE;
        end else if ({1'b0, r_len} > MAX_LEN_C) begin
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_WR_ADDR;
        end
      end

      S_WR_ADDR, S_WR_LEN, S_WR_CTRL: begin
        if (!r_cyc) begin
          // Open the access; everything stays frozen until ack or timeout.
          w_cyc_next     = 1'b1;
          w_we_next      = 1'b1;
          w_adr_next     = w_wr_adr;
          w_dat_next     = w_wr_dat;
          w_ack_cnt_next = '0;
        end else if (ack_i) begin
          w_cyc_next   = 1'b0;
          w_we_next    = 1'b0;
          w_state_next = w_wr_next;
          if (r_state == S_WR_CTRL) begin
            w_busy_cnt_next = '0;
          end
        end else if (w_ack_expired) begin
          w_cyc_next   = 1'b0;
          w_we_next    = 1'b0;
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_ack_cnt_next = r_ack_cnt + 1'b1;
        end
      end

      S_POLL_RD: begin
        if (w_busy_expired) begin
          w_cyc_next   = 1'b0;
          w_we_next    = 1'b0;
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_busy_cnt_next = r_busy_cnt + 1'b1;
          if (!r_cyc) begin
            w_cyc_next     = 1'b1;
            w_we_next      = 1'b0;
            w_adr_next     = ADR_CTRL;
            w_dat_next     = '0;
            w_ack_cnt_next = '0;
          end else if (ack_i) begin
            w_cyc_next = 1'b0;
            if (dat_i[0]) begin
              w_gap_cnt_next = '0;
              w_state_next   = S_POLL_WAIT;
            end else begin
              w_state_next = S_DONE;
            end
          end else if (w_ack_expired) begin
            w_cyc_next   = 1'b0;
            w_err_next   = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_ack_cnt_next = r_ack_cnt + 1'b1;
          end
        end
      end

      S_POLL_WAIT: begin
        if (w_busy_expired) begin
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_busy_cnt_next = r_busy_cnt + 1'b1;
          if (r_gap_cnt == GAP_LAST) begin
            // Launch the next read directly so the idle gap is exactly POLL_GAP.
            w_state_next   = S_POLL_RD;
            w_cyc_next     = 1'b1;
            w_we_next      = 1'b0;
            w_adr_next     = ADR_CTRL;
            w_dat_next     = '0;
            w_ack_cnt_next = '0;
          end else begin
            w_gap_cnt_next = r_gap_cnt + 1'b1;
          end
        end
      end

      S_DONE: begin
        w_cyc_next   = 1'b0;
        w_we_next    = 1'b0;
        w_gnt_next   = '0;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
        w_cyc_next   = 1'b0;
        w_we_next    = 1'b0;
        w_gnt_next   = '0;
      end
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_ptr      <= PTR_W'(N_REQ - 1);
      r_gnt      <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_ack_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_gnt      <= w_gnt_next;
      r_addr     <= w_addr_next;
      r_len      <= w_len_next;
      r_err      <= w_err_next;
      r_cyc      <= w_cyc_next;
      r_we       <= w_we_next;
      r_adr      <= w_adr_next;
      r_dat      <= w_dat_next;
      r_ack_cnt  <= w_ack_cnt_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_busy_cnt <= w_busy_cnt_next;
    end
  end

  assign gnt_o  = r_gnt;
  assign done_o = (r_state == S_DONE) ? r_gnt : '0;
  assign err_o  = ((r_state == S_DONE) && r_err) ? r_gnt : '0;
  assign adr_o  = r_adr;
  assign dat_o  = r_dat;
  assign we_o   = r_we;
  assign stb_o  = r_cyc;
  assign cyc_o  = r_cyc;
  assign sel_o  = '1;
  assign cti_o  = 3'b000;
  assign busy_o = (r_state != S_IDLE);

endmodule
